// File: rtl/la_trigger_capture.sv
// Logic-analyser capture engine: arm on sample_run, wait for a trigger, pack strobed samples into words.
// Optional `LA_WORD_TAG_EN: pad bits carry last-word (MSB) and first/trigger-word (MSB-1) flags.
module la_trigger_capture #(
   parameter int INPUT_WIDTH = 6,
   parameter int OUT_WIDTH   = 32,
   parameter int DIV_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [INPUT_WIDTH-1:0] din,
   input  logic                   sample_run,
   input  logic [31:0]            sample_num,
   input  logic [3:0]             sample_clk_cfg,
   input  logic [1:0]             triger_type,
   input  logic [2:0]             trigger_channel,
   output logic [OUT_WIDTH-1:0]   dout_data,
   output logic                   dout_valid,
   input  logic                   dout_ready,
   output logic                   busy,
   output logic                   triggered,
   output logic                   capture_done,
   output logic                   overflow
);
   localparam int SPW    = OUT_WIDTH / INPUT_WIDTH;
   localparam int SLOT_W = $clog2(SPW + 1);

   typedef enum logic [2:0] {IDLE, ARM, CAPTURE, FLUSH, DONE} state_t;
   state_t state, state_next;

   logic [INPUT_WIDTH-1:0] sync1, din_s;
   logic                   run_d1, run_d2;
   logic [3:0]             cfg_lat;
   logic [1:0]             type_lat;
   logic [2:0]             ch_lat;
   logic [31:0]            num_lat, count;
   logic [DIV_WIDTH-1:0]   div, div_max;
   logic                   prev_bit, have_prev, first_word;
   logic [OUT_WIDTH-1:0]   pack, word_acc, word_out, data_reg;
   logic [SLOT_W-1:0]      slot, slot_inc;
   logic                   valid_reg, trig_reg, ovf_reg;

   logic start, abort, strobe, sel_bit, immediate, edge_hit, trig_hit, cap;
   logic is_last, word_full, emit, can_load;
   logic [31:0] count_inc;

   always_comb begin
      start      = (state == IDLE) && run_d1 && !run_d2;
      abort      = ((state == ARM) || (state == CAPTURE) || (state == FLUSH)) && !sample_run;
      div_max    = (DIV_WIDTH'(1) << cfg_lat) - DIV_WIDTH'(1);
      strobe     = ((state == ARM) || (state == CAPTURE)) && (div == div_max);
      sel_bit    = |(din_s & (INPUT_WIDTH'(1) << ch_lat));
      immediate  = (type_lat == 2'b11) || (int'(ch_lat) >= INPUT_WIDTH);
      edge_hit   = 1'b0;
      case (type_lat)
         2'b00:   edge_hit = !prev_bit && sel_bit;
         2'b01:   edge_hit = prev_bit && !sel_bit;
         2'b10:   edge_hit = prev_bit ^ sel_bit;
         default: edge_hit = 1'b0;
      endcase
      trig_hit   = (state == ARM) && strobe && (immediate || (have_prev && edge_hit));
      cap        = trig_hit || ((state == CAPTURE) && strobe);
      count_inc  = count + 32'd1;
      slot_inc   = slot + SLOT_W'(1);
      is_last    = (count_inc == num_lat);
      word_full  = (slot_inc == SLOT_W'(SPW)) || is_last;
      word_acc   = pack | (OUT_WIDTH'(din_s) << (INPUT_WIDTH * int'(slot)));
      word_out   = word_acc;
`ifdef LA_WORD_TAG_EN
      word_out[OUT_WIDTH-1] = is_last;
      word_out[OUT_WIDTH-2] = first_word || trig_hit;
`endif
      emit       = cap && word_full && !abort;
      can_load   = !valid_reg || dout_ready;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = (sample_num == 32'd0) ? DONE : ARM;
         ARM:     if (trig_hit) state_next = is_last ? FLUSH : CAPTURE;
         CAPTURE: if (cap && is_last) state_next = FLUSH;
         FLUSH:   if (!valid_reg || dout_ready) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (abort) state_next = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;  din_s <= '0;  run_d1 <= 1'b0;  run_d2 <= 1'b0;
         cfg_lat <= '0;  type_lat <= '0;  ch_lat <= '0;  num_lat <= '0;
         div <= '0;  count <= '0;  slot <= '0;  pack <= '0;
         prev_bit <= 1'b0;  have_prev <= 1'b0;  first_word <= 1'b0;
         data_reg <= '0;  valid_reg <= 1'b0;  trig_reg <= 1'b0;  ovf_reg <= 1'b0;
      end else begin
         sync1  <= din;
         din_s  <= sync1;
         run_d1 <= sample_run;
         run_d2 <= run_d1;
         if (start) begin
            cfg_lat    <= sample_clk_cfg;
            type_lat   <= triger_type;
            ch_lat     <= trigger_channel;
            num_lat    <= sample_num;
            div        <= '0;
            count      <= '0;
            slot       <= '0;
            pack       <= '0;
            have_prev  <= 1'b0;
            first_word <= 1'b0;
            ovf_reg    <= 1'b0;
         end else begin
            if ((state == ARM) || (state == CAPTURE))
               div <= strobe ? '0 : div + DIV_WIDTH'(1);
            if ((state == ARM) && strobe) begin
               prev_bit  <= sel_bit;
               have_prev <= 1'b1;
            end
            if (cap) begin
               count <= count_inc;
               pack  <= word_full ? '0 : word_acc;
               slot  <= word_full ? '0 : slot_inc;
            end
            if (emit)          first_word <= 1'b0;
            else if (trig_hit) first_word <= 1'b1;
            if (emit && !can_load) ovf_reg <= 1'b1;
         end
         // Abort wins over any word completing in the same cycle.
         if (abort)                    valid_reg <= 1'b0;
         else if (emit && can_load) begin
            data_reg  <= word_out;
            valid_reg <= 1'b1;
         end else if (valid_reg && dout_ready) valid_reg <= 1'b0;
         if (state_next == IDLE) trig_reg <= 1'b0;
         else if (trig_hit)      trig_reg <= 1'b1;
      end
   end

   assign dout_data    = data_reg;
   assign dout_valid   = valid_reg;
   assign busy         = (state == ARM) || (state == CAPTURE) || (state == FLUSH);
   assign triggered    = trig_reg;
   assign capture_done = (state == DONE);
   assign overflow     = ovf_reg;
endmodule

// File: tb/tb_la_trigger_capture.sv
// Directed bench for la_trigger_capture: a sample-stream model predicts words, timing and overflow.
module tb_la_trigger_capture;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  din = '0;
   logic        sample_run = 1'b0;
   logic [31:0] sample_num = '0;
   logic [3:0]  sample_clk_cfg = '0;
   logic [1:0]  triger_type = '0;
   logic [2:0]  trigger_channel = '0;
   logic [31:0] dout_data;
   logic        dout_valid;
   logic        dout_ready = 1'b1;
   logic        busy, triggered, capture_done, overflow;

   int checks = 0;
   int errors = 0;
   logic [5:0]  din_vec [256];
   logic [31:0] exp_q [$];
   int t_rel = 0;
   bit in_test = 0;
   int ovf_t = 0;
   int exp_done = 0;
   bit exp_trig = 0;
   int done_cnt = 0, done_t = 0, acc_t = 0;
   bit hold_v = 0;
   logic [31:0] hold_d = '0;

   always #5 clk = ~clk;

   la_trigger_capture #(.INPUT_WIDTH(6), .OUT_WIDTH(32), .DIV_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .sample_run(sample_run), .sample_num(sample_num),
      .sample_clk_cfg(sample_clk_cfg), .triger_type(triger_type), .trigger_channel(trigger_channel),
      .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy),
      .triggered(triggered), .capture_done(capture_done), .overflow(overflow));

   function automatic logic [5:0] samp(input int j, input int d);
      int idx;
      idx = j * d + d - 1;
      if (idx > 255) idx = 255;
      return din_vec[idx];
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   // Sample j is the synchronised input seen at strobe j; words are groups of 5 samples from the trigger.
   task automatic build(input int cfg, input int typ, input int ch, input int num, input bit ready_late);
      int d, jt;
      bit cur, prv;
      logic [5:0] a, b;
      logic [31:0] w;
      d = 1 << cfg;
      jt = -1;
      exp_q.delete();
      for (int j = 0; (j * d + d - 1 < 256) && (jt < 0); j++) begin
         if (typ == 3 || ch >= 6) jt = 0;
         else if (j > 0) begin
            a = samp(j, d);
            b = samp(j - 1, d);
            cur = a[ch];
            prv = b[ch];
            if ((typ == 0 && !prv && cur) || (typ == 1 && prv && !cur) || (typ == 2 && prv != cur)) jt = j;
         end
      end
      if (jt < 0) jt = 0;
      for (int k = 0; k < num; k += 5) begin
         w = '0;
         for (int s = 0; s < 5 && k + s < num; s++) w = w | (32'(samp(jt + k + s, d)) << (6 * s));
`ifdef LA_WORD_TAG_EN
         w[31] = (k + 5 >= num);
         w[30] = (k == 0);
`endif
         exp_q.push_back(w);
      end
      exp_done = (num == 0) ? 2 : 2 + (jt + num - 1) * d + (d - 1) + 2;
      ovf_t = (ready_late && num > 5) ? 2 + (jt + ((num < 10) ? num : 10) - 1) * d + d : 0;
      if (ready_late) while (exp_q.size() > 1) void'(exp_q.pop_back());
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (dout_valid && hold_v) check("data_stable", dout_data, hold_d);
         hold_v = dout_valid && !dout_ready;
         hold_d = dout_data;
         if (dout_valid && dout_ready) begin
            acc_t = t_rel;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL word_unexpected got %h want none", dout_data);
            end else check("word", dout_data, exp_q.pop_front());
         end
         if (capture_done) begin
            done_cnt++;
            done_t = t_rel;
            check("trig_at_done", 32'(triggered), 32'(exp_trig));
         end
         if (in_test && t_rel >= 2) check("overflow", 32'(overflow), 32'(ovf_t > 0 && t_rel >= ovf_t));
      end
   end

   task automatic run(input int cfg, input int typ, input int ch, input int num, input int ready_at,
                      input int abort_at, input int pin_idx, input logic [31:0] pin_val);
      int step;
      bit fin;
      build(cfg, typ, ch, num, ready_at > 0);
      if (pin_idx >= 0) check("model_pin", exp_q[pin_idx], pin_val);
      sample_clk_cfg = 4'(cfg);
      triger_type = 2'(typ);
      trigger_channel = 3'(ch);
      sample_num = 32'(num);
      dout_ready = (ready_at == 0);
      exp_trig = (num > 0);
      done_cnt = 0;
      acc_t = -1;
      @(posedge clk);
      #1;
      t_rel = 0;
      in_test = 1;
      sample_run = 1'b1;
      din = din_vec[0];
      fin = 0;
      for (step = 1; step < 400 && !fin; step++) begin
         @(posedge clk);
         #1;
         t_rel = step;
         din = din_vec[(step < 256) ? step : 255];
         if (ready_at > 0 && step == ready_at - 1) begin
            check("flush_busy", 32'(busy), 32'd1);
            check("flush_valid", 32'(dout_valid), 32'd1);
         end
         if (ready_at > 0 && step == ready_at) dout_ready = 1'b1;
         if (abort_at > 0 && step == abort_at) sample_run = 1'b0;
         if (abort_at > 0 && step == abort_at + 1) begin
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_valid", 32'(dout_valid), 32'd0);
            check("abort_trig", 32'(triggered), 32'd0);
         end
         if (abort_at > 0 && step >= abort_at + 8) fin = 1;
         if (abort_at == 0 && done_cnt > 0 && step >= done_t + 3) fin = 1;
      end
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL timeout got no completion want capture_done");
      end
      if (abort_at > 0) begin
         check("abort_no_done", 32'(done_cnt), 32'd0);
         check("abort_left", 32'(exp_q.size()), 32'(((num + 4) / 5) - 1));
         exp_q.delete();
      end else begin
         check("done_count", 32'(done_cnt), 32'd1);
         check("done_time", 32'(done_t), 32'((ready_at == 0) ? exp_done : ready_at + 1));
         check("words_left", 32'(exp_q.size()), 32'd0);
         if (num > 0) check("done_after_accept", 32'(done_t), 32'(acc_t + 1));
      end
      sample_run = 1'b0;
      in_test = 0;
      dout_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #7;
      check("rst_valid", 32'(dout_valid), 32'd0);
      check("rst_data", dout_data, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_trig", 32'(triggered), 32'd0);
      check("rst_done", 32'(capture_done), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Immediate trigger, samples 1..5.
      for (int t = 0; t < 256; t++) din_vec[t] = 6'(t + 1);
`ifdef LA_WORD_TAG_EN
      run(0, 3, 0, 5, 0, 0, 0, 32'hC510_3081);
`else
      run(0, 3, 0, 5, 0, 0, 0, 32'h0510_3081);
`endif
      // Rising edge on channel 2 at sample 40.
      for (int t = 0; t < 256; t++) din_vec[t] = 6'((t & 8'h3B) | ((t >= 40) ? 4 : 0));
`ifdef LA_WORD_TAG_EN
      run(0, 0, 2, 7, 0, 0, 1, 32'h8000_0BAD);
`else
      run(0, 0, 2, 7, 0, 0, 1, 32'h0000_0BAD);
`endif
      // Divided rate: strobe every 8 cycles.
      for (int t = 0; t < 256; t++) din_vec[t] = 6'(t * 3);
      run(3, 3, 0, 10, 0, 0, -1, '0);
      // Out-of-range channel behaves as immediate.
      for (int t = 0; t < 256; t++) din_vec[t] = 6'(t ^ 8'h15);
      run(0, 0, 7, 3, 0, 0, -1, '0);
      // Either-edge trigger (falling) at cfg=1.
      for (int t = 0; t < 256; t++) din_vec[t] = 6'((t < 20) ? (t | 1) : (t & 8'h3E));
      run(1, 2, 0, 6, 0, 0, -1, '0);
      // Backpressure: only the first word survives, overflow sticks, FLUSH waits for ready.
      for (int t = 0; t < 256; t++) din_vec[t] = 6'(t * 5 + 7);
      run(0, 3, 0, 15, 40, 0, -1, '0);
      // Abort mid-capture; restart also clears overflow.
      for (int t = 0; t < 256; t++) din_vec[t] = 6'(t + 9);
      run(0, 3, 0, 20, 0, 10, -1, '0);
      // Zero-depth capture.
      run(0, 3, 0, 0, 0, 0, -1, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
